// File: rtl/bw_bbox_scan_pkg.sv
// Shared constants and handshake state encoding for the bw_image reader and writer blocks.
package bw_bbox_scan_pkg;

  localparam int BW_IMG_W   = 320;
  localparam int BW_IMG_H   = 240;
  localparam int BW_ADDR_W  = 17;
  localparam int BW_COORD_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } hs_state_t;

endpackage

// File: rtl/bw_bbox_scan_accum.sv
// Valid-gated running min/max/hit for the x and y lanes, committed to registered outputs.
module bbox_accum #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         valid,
  input  logic [W-1:0] px_x,
  input  logic [W-1:0] px_y,
  input  logic         commit,
  output logic         found,
  output logic [W-1:0] x_min,
  output logic [W-1:0] x_max,
  output logic [W-1:0] y_min,
  output logic [W-1:0] y_max
);

  logic [W-1:0] ax_min, ax_max, ay_min, ay_max;
  logic [W-1:0] nx_min, nx_max, ny_min, ny_max;
  logic         hit, nhit;

  always_comb begin
    nx_min = ax_min;
    nx_max = ax_max;
    ny_min = ay_min;
    ny_max = ay_max;
    nhit   = hit;
    if (valid) begin
      if (px_x < ax_min) nx_min = px_x;
      if (px_x > ax_max) nx_max = px_x;
      if (px_y < ay_min) ny_min = px_y;
      if (px_y > ay_max) ny_max = px_y;
      nhit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ax_min <= '1;
      ax_max <= '0;
      ay_min <= '1;
      ay_max <= '0;
      hit    <= 1'b0;
    end else if (clear) begin
      ax_min <= '1;
      ax_max <= '0;
      ay_min <= '1;
      ay_max <= '0;
      hit    <= 1'b0;
    end else begin
      ax_min <= nx_min;
      ax_max <= nx_max;
      ay_min <= ny_min;
      ay_max <= ny_max;
      hit    <= nhit;
    end
  end

  // Commit uses the next-state values so a pixel arriving on the commit edge is included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      found <= 1'b0;
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
    end else if (commit) begin
      found <= nhit;
      x_min <= nhit ? nx_min : '0;
      x_max <= nhit ? nx_max : '0;
      y_min <= nhit ? ny_min : '0;
      y_max <= nhit ? ny_max : '0;
    end
  end

endmodule

// File: rtl/bw_bbox_scan.sv
// Raster scan of the 1-bit bw_image buffer reporting the bounding box of set pixels.
//   state | meaning
//   IDLE  | waiting for start; last result held on outputs
//   SCAN  | one read address per cycle, raster order
//   DRAIN | waiting RD_LAT cycles for the last read data
//   DONE  | result committed, done held until ack
module bw_bbox_scan
  import bw_bbox_scan_pkg::*;
#(
  parameter int IMG_W   = BW_IMG_W,
  parameter int IMG_H   = BW_IMG_H,
  parameter int ADDR_W  = BW_ADDR_W,
  parameter int COORD_W = BW_COORD_W,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ack,
  output logic               done,
  output logic               busy,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_data,
  output logic               found,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max
);

  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(IMG_W - 1);

  hs_state_t          state;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [DW-1:0]      drain_cnt;

  logic               v_pipe [RD_LAT];
  logic [COORD_W-1:0] x_pipe [RD_LAT];
  logic [COORD_W-1:0] y_pipe [RD_LAT];

  logic clear, commit, pix_valid;

  assign clear     = (state == ST_IDLE) && start;
  assign commit    = (state == ST_DRAIN) && (drain_cnt == '0);
  assign pix_valid = v_pipe[RD_LAT-1] && rd_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SCAN;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
          end
        end
        ST_SCAN: begin
          if (rd_addr == LAST_ADDR) begin
            state     <= ST_DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= DW'(RD_LAT - 1);
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (x_cnt == LAST_X) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + COORD_W'(1);
            end else begin
              x_cnt <= x_cnt + COORD_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        ST_DONE: begin
          if (ack) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pixel coordinates travel with the read so they line up with rd_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        v_pipe[i] <= 1'b0;
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= rd_en;
      x_pipe[0] <= x_cnt;
      y_pipe[0] <= y_cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        x_pipe[i] <= x_pipe[i-1];
        y_pipe[i] <= y_pipe[i-1];
      end
    end
  end

  bbox_accum #(.W(COORD_W)) u_accum (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .valid  (pix_valid),
    .px_x   (x_pipe[RD_LAT-1]),
    .px_y   (y_pipe[RD_LAT-1]),
    .commit (commit),
    .found  (found),
    .x_min  (x_min),
    .x_max  (x_max),
    .y_min  (y_min),
    .y_max  (y_max)
  );

endmodule

// File: tb/tb_bw_bbox_scan.sv
// Self-checking bench for bw_bbox_scan on an 8x4 image with a registered 1-bit memory model.
module tb_bw_bbox_scan;
  import bw_bbox_scan_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int CW = 9;
  localparam int LAT_EDGES = N + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  logic          done, busy, rd_en, found;
  logic [16:0]   rd_addr;
  logic          rd_data = 1'b0;
  logic [CW-1:0] x_min, x_max, y_min, y_max;

  logic          mem [N];
  logic [4*CW:0] outv;

  int tests = 0;
  int fails = 0;

  assign outv = {found, x_min, x_max, y_min, y_max};

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr[4:0]];

  bw_bbox_scan #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(17), .COORD_W(CW), .RD_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .done(done), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .found(found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
  );

  // Reference: bounding box straight from the pixel list, coordinates from address arithmetic.
  function automatic logic [4*CW:0] model();
    int xl = W, xh = -1, yl = H, yh = -1;
    for (int i = 0; i < N; i++) begin
      if (mem[i]) begin
        if (i % W < xl) xl = i % W;
        if (i % W > xh) xh = i % W;
        if (i / W < yl) yl = i / W;
        if (i / W > yh) yh = i / W;
      end
    end
    if (xh < 0) return '0;
    return {1'b1, CW'(xl), CW'(xh), CW'(yl), CW'(yh)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 1'b0;
  endtask

  task automatic start_scan();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic scan_and_check(input string name);
    int n;
    logic [4*CW:0] exp_v;
    exp_v = model();
    start_scan();
    wait_done(n);
    tests++;
    if (n !== LAT_EDGES) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, n, LAT_EDGES);
    end
    tests++;
    if (outv !== exp_v) begin
      fails++;
      $display("FAIL %s bbox: got %h, expected %h", name, outv, exp_v);
    end
    do_ack();
  endtask

  task automatic test_reset();
    clear_mem();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({done, busy, rd_en, rd_addr, outv} !== '0 || dut.state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_state: got done=%b busy=%b rd_en=%b addr=%0d out=%h",
               done, busy, rd_en, rd_addr, outv);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_empty();
    int n, en, err;
    clear_mem();
    en = 0; err = 0; n = 0;
    start_scan();
    while (!done && n < 200) begin
      if (rd_en) begin
        if (rd_addr !== 17'(en)) err++;
        en++;
      end
      @(posedge clk); #1; n++;
    end
    tests++;
    if (n !== LAT_EDGES) begin
      fails++;
      $display("FAIL empty latency: got %0d edges, expected %0d", n, LAT_EDGES);
    end
    tests++;
    if (en !== N || err !== 0) begin
      fails++;
      $display("FAIL empty rd_seq: got %0d reads with %0d order errors, expected %0d reads, 0 errors", en, err, N);
    end
    tests++;
    if (outv !== '0) begin
      fails++;
      $display("FAIL empty bbox: got %h, expected 0", outv);
    end
    do_ack();
  endtask

  task automatic test_single();
    clear_mem();
    mem[21] = 1'b1;
    scan_and_check("single");
  endtask

  task automatic test_corners();
    clear_mem();
    mem[0] = 1'b1;
    mem[N-1] = 1'b1;
    scan_and_check("corners");
  endtask

  task automatic test_spread_hold();
    int n;
    logic [4*CW:0] prev;
    logic [4*CW:0] mid;
    clear_mem();
    mem[6] = 1'b1;
    mem[1*W + 1] = 1'b1;
    mem[3*W + 3] = 1'b1;
    scan_and_check("spread");
    prev = {1'b1, CW'(1), CW'(6), CW'(0), CW'(3)};
    clear_mem();
    start_scan();
    repeat (16) @(posedge clk);
    #1;
    mid = outv;
    wait_done(n);
    tests++;
    if (mid !== prev) begin
      fails++;
      $display("FAIL hold_during_scan: got %h, expected %h", mid, prev);
    end
    tests++;
    if (outv !== '0 || !done) begin
      fails++;
      $display("FAIL empty_after_spread: got %h done=%b, expected 0 done=1", outv, done);
    end
    do_ack();
  endtask

  task automatic test_ack_hold();
    int n, unstable;
    logic [4*CW:0] snap;
    clear_mem();
    mem[6] = 1'b1;
    mem[1*W + 1] = 1'b1;
    mem[3*W + 3] = 1'b1;
    start_scan();
    wait_done(n);
    snap = outv;
    unstable = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || outv !== snap) unstable++;
    end
    tests++;
    if (unstable !== 0 || snap !== model()) begin
      fails++;
      $display("FAIL ack_hold: %0d unstable cycles, out %h, expected %h", unstable, snap, model());
    end
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
    tests++;
    if (done !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || dut.state !== ST_IDLE) begin
      fails++;
      $display("FAIL ack_release: got done=%b rd_en=%b busy=%b, expected all 0 in IDLE", done, rd_en, busy);
    end
  endtask

  task automatic test_start_ack_overlap();
    int n;
    clear_mem();
    mem[10] = 1'b1;
    start_scan();
    wait_done(n);
    @(negedge clk); start = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_ack_same_cycle: got done=%b busy=%b, expected 0 0", done, busy);
    end
    @(negedge clk); ack = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    tests++;
    if (busy !== 1'b1 || rd_addr !== '0) begin
      fails++;
      $display("FAIL start_held_restart: got busy=%b addr=%0d, expected 1 0", busy, rd_addr);
    end
    wait_done(n);
    tests++;
    if (outv !== model()) begin
      fails++;
      $display("FAIL restart_bbox: got %h, expected %h", outv, model());
    end
    do_ack();
  endtask

  task automatic test_reset_mid_scan();
    clear_mem();
    mem[21] = 1'b1;
    start_scan();
    repeat (9) @(posedge clk);
    #2; reset = 1'b0;
    #1;
    tests++;
    if ({done, busy, rd_en, rd_addr, outv} !== '0) begin
      fails++;
      $display("FAIL reset_mid_scan: got done=%b busy=%b rd_en=%b addr=%0d out=%h",
               done, busy, rd_en, rd_addr, outv);
    end
    @(negedge clk); reset = 1'b1;
    scan_and_check("after_reset");
  endtask

  task automatic test_random();
    int dens;
    for (int k = 0; k < 6; k++) begin
      dens = (k % 3 == 0) ? 3 : ((k % 3 == 1) ? 10 : 40);
      for (int i = 0; i < N; i++) mem[i] = ($urandom_range(0, 99) < dens);
      scan_and_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_corners();
    test_spread_hold();
    test_ack_hold();
    test_start_ack_overlap();
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
